// File: rtl/boot_loader.sv
// Boot loader: holds the core in reset, assembles a little-endian byte stream into 32-bit words
// and writes them into DRAM via a grant handshake. Optional checksum phase: BOOT_CHECKSUM_EN.
module boot_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int          NUM_WORDS      = 32,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_start_ip,
  input  logic        byte_valid_ip,
  input  logic [7:0]  byte_data_ip,
  output logic        byte_ready_op,
  output logic        wr_en_op,
  output logic [31:0] wr_addr_op,
  output logic [31:0] wr_data_op,
  input  logic        wr_gnt_ip,
  output logic        core_reset_op,
  output logic        mem_en_op,
  output logic        done_op,
  output logic        error_op
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [8:0] MAX_N = 9'(NUM_WORDS);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_RECV  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;
`ifdef BOOT_CHECKSUM_EN
  localparam logic [2:0] S_CHECK = 3'd6;
`endif

  logic [2:0]       state;
  logic [7:0]       word_cnt;
  logic [7:0]       words_written;
  logic [1:0]       byte_idx;
  logic [TMO_W-1:0] tmo_cnt;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]       checksum;
`endif

  logic byte_xfer;
  logic active;
  logic progress;
  logic tmo_hit;
  logic last_word;
  logic hdr_bad;

  assign byte_xfer = byte_valid_ip && byte_ready_op;
`ifdef BOOT_CHECKSUM_EN
  assign active    = (state == S_HDR) || (state == S_RECV) || (state == S_WRITE) ||
                     (state == S_CHECK);
`else
  assign active    = (state == S_HDR) || (state == S_RECV) || (state == S_WRITE);
`endif
  assign progress  = byte_xfer || ((state == S_WRITE) && wr_gnt_ip);
  // Timeout fires on the edge that would complete the TIMEOUT_CYCLES-th idle cycle.
  assign tmo_hit   = active && !progress && (tmo_cnt == TMO_LAST);
  assign last_word = (words_written + 8'd1) == word_cnt;
  assign hdr_bad   = (byte_data_ip == 8'd0) || ({1'b0, byte_data_ip} > MAX_N);

  always_ff @(posedge clock) begin
    if (reset || !active || progress) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      byte_ready_op <= 1'b0;
      wr_en_op      <= 1'b0;
      wr_addr_op    <= BASE_ADDR;
      wr_data_op    <= 32'h0;
      core_reset_op <= 1'b1;
      mem_en_op     <= 1'b0;
      done_op       <= 1'b0;
      error_op      <= 1'b0;
      word_cnt      <= 8'd0;
      words_written <= 8'd0;
      byte_idx      <= 2'd0;
`ifdef BOOT_CHECKSUM_EN
      checksum      <= 8'd0;
`endif
    end else begin
      case (state)
        S_IDLE, S_ERROR: begin
          if (load_start_ip) begin
            state         <= S_HDR;
            byte_ready_op <= 1'b1;
            error_op      <= 1'b0;
            wr_addr_op    <= BASE_ADDR;
            word_cnt      <= 8'd0;
            words_written <= 8'd0;
            byte_idx      <= 2'd0;
`ifdef BOOT_CHECKSUM_EN
            checksum      <= 8'd0;
`endif
          end
        end
        S_HDR: begin
          if (tmo_hit) begin
            state         <= S_ERROR;
            error_op      <= 1'b1;
            byte_ready_op <= 1'b0;
          end else if (byte_xfer) begin
            word_cnt <= byte_data_ip;
            if (hdr_bad) begin
              state         <= S_ERROR;
              error_op      <= 1'b1;
              byte_ready_op <= 1'b0;
            end else begin
              state <= S_RECV;
            end
          end
        end
        S_RECV: begin
          if (tmo_hit) begin
            state         <= S_ERROR;
            error_op      <= 1'b1;
            byte_ready_op <= 1'b0;
          end else if (byte_xfer) begin
            wr_data_op[{byte_idx, 3'b000} +: 8] <= byte_data_ip;
            byte_idx <= byte_idx + 2'd1;
`ifdef BOOT_CHECKSUM_EN
            checksum <= checksum ^ byte_data_ip;
`endif
            if (byte_idx == 2'd3) begin
              state         <= S_WRITE;
              byte_ready_op <= 1'b0;
              wr_en_op      <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (tmo_hit) begin
            state    <= S_ERROR;
            error_op <= 1'b1;
            wr_en_op <= 1'b0;
          end else if (wr_gnt_ip) begin
            wr_en_op      <= 1'b0;
            words_written <= words_written + 8'd1;
            if (last_word) begin
              // Address stays on the final word so it never passes the region end.
`ifdef BOOT_CHECKSUM_EN
              state         <= S_CHECK;
              byte_ready_op <= 1'b1;
`else
              state         <= S_DONE;
              done_op       <= 1'b1;
              core_reset_op <= 1'b0;
              mem_en_op     <= 1'b1;
`endif
            end else begin
              state         <= S_RECV;
              wr_addr_op    <= wr_addr_op + 32'd4;
              byte_ready_op <= 1'b1;
            end
          end
        end
`ifdef BOOT_CHECKSUM_EN
        S_CHECK: begin
          if (tmo_hit) begin
            state         <= S_ERROR;
            error_op      <= 1'b1;
            byte_ready_op <= 1'b0;
          end else if (byte_xfer) begin
            byte_ready_op <= 1'b0;
            if (byte_data_ip == checksum) begin
              state         <= S_DONE;
              done_op       <= 1'b1;
              core_reset_op <= 1'b0;
              mem_en_op     <= 1'b1;
            end else begin
              state    <= S_ERROR;
              error_op <= 1'b1;
            end
          end
        end
`endif
        S_DONE: begin
          state <= S_DONE;
        end
        default: begin
          state         <= S_IDLE;
          byte_ready_op <= 1'b0;
          wr_en_op      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: cycle table for the basic load / bad header flows, then hand sequences
// for region-size limits, grant stalls, timeout, mid-load reset and the checksum option.
module tb_boot_loader;

  localparam int TMO = 1024;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_start_ip;
  logic        byte_valid_ip;
  logic [7:0]  byte_data_ip;
  logic        byte_ready_op;
  logic        wr_en_op;
  logic [31:0] wr_addr_op;
  logic [31:0] wr_data_op;
  logic        wr_gnt_ip;
  logic        core_reset_op;
  logic        mem_en_op;
  logic        done_op;
  logic        error_op;

  always #5 clock = ~clock;

  boot_loader #(
    .BASE_ADDR      (32'h0),
    .NUM_WORDS      (32),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .load_start_ip (load_start_ip),
    .byte_valid_ip (byte_valid_ip),
    .byte_data_ip  (byte_data_ip),
    .byte_ready_op (byte_ready_op),
    .wr_en_op      (wr_en_op),
    .wr_addr_op    (wr_addr_op),
    .wr_data_op    (wr_data_op),
    .wr_gnt_ip     (wr_gnt_ip),
    .core_reset_op (core_reset_op),
    .mem_en_op     (mem_en_op),
    .done_op       (done_op),
    .error_op      (error_op)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // DRAM side: every granted write is logged.
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  always @(posedge clock) begin
    if (!reset && wr_en_op && wr_gnt_ip) begin
      log_addr.push_back(wr_addr_op);
      log_data.push_back(wr_data_op);
    end
  end

  typedef struct {
    logic        rst, start, valid;
    logic [7:0]  data;
    logic        gnt;
    logic        ready, wr_en;
    logic [31:0] addr, wdata;
    logic        cr, mem, done, err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic start, logic valid, logic [7:0] data, logic gnt,
                              logic ready, logic wr_en, logic [31:0] addr, logic [31:0] wdata,
                              logic cr, logic mem, logic done, logic err);
    vec_t v;
    v.rst = rst; v.start = start; v.valid = valid; v.data = data; v.gnt = gnt;
    v.ready = ready; v.wr_en = wr_en; v.addr = addr; v.wdata = wdata;
    v.cr = cr; v.mem = mem; v.done = done; v.err = err;
    return v;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; load_start_ip = 1'b0; byte_valid_ip = 1'b0; byte_data_ip = 8'h00;
    @(posedge clock); #1;
    reset = 1'b0;
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic pulse_start();
    load_start_ip = 1'b1;
    @(posedge clock); #1;
    load_start_ip = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    int n = 0;
    while (!byte_ready_op && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    if (!byte_ready_op) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_byte: byte_ready got 0, want 1 within 50 cycles");
    end
    byte_valid_ip = 1'b1;
    byte_data_ip  = d;
    @(posedge clock); #1;
    byte_valid_ip = 1'b0;
  endtask

  task automatic wait_done_or_error();
    int n = 0;
    while (!done_op && !error_op && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
  endtask

  initial begin
    logic [7:0]  s1 [0:8];
    logic [7:0]  b;
    logic [7:0]  xsum;
    logic [31:0] w;

    reset = 1'b1; load_start_ip = 1'b0; byte_valid_ip = 1'b0; byte_data_ip = 8'h00;
    wr_gnt_ip = 1'b1;
    s1 = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

    // Basic two-word load with grant always high.
    vecs.push_back(mk(1, 0, 0, 8'h00, 1,  0, 0, 32'h0, 32'h0,        1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1,  1, 0, 32'h0, 32'h0,        1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h02, 1,  1, 0, 32'h0, 32'h0,        1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h13, 1,  1, 0, 32'h0, 32'h13,       1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 1,  1, 0, 32'h0, 32'h13,       1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 1,  1, 0, 32'h0, 32'h13,       1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 1,  0, 1, 32'h0, 32'h13,       1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h93, 1,  1, 0, 32'h4, 32'h13,       1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h93, 1,  1, 0, 32'h4, 32'h93,       1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 1,  1, 0, 32'h4, 32'h93,       1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h10, 1,  1, 0, 32'h4, 32'h00100093, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 1,  0, 1, 32'h4, 32'h00100093, 1, 0, 0, 0));
`ifdef BOOT_CHECKSUM_EN
    vecs.push_back(mk(0, 0, 0, 8'h00, 1,  1, 0, 32'h4, 32'h00100093, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h90, 1,  0, 0, 32'h4, 32'h00100093, 0, 1, 1, 0));
`else
    vecs.push_back(mk(0, 0, 0, 8'h00, 1,  0, 0, 32'h4, 32'h00100093, 0, 1, 1, 0));
`endif
    vecs.push_back(mk(0, 1, 1, 8'h55, 1,  0, 0, 32'h4, 32'h00100093, 0, 1, 1, 0));
    // Zero header fails, a later start recovers.
    vecs.push_back(mk(1, 0, 0, 8'h00, 1,  0, 0, 32'h0, 32'h0,        1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1,  1, 0, 32'h0, 32'h0,        1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 1,  0, 0, 32'h0, 32'h0,        1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 8'h05, 1,  0, 0, 32'h0, 32'h0,        1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1,  1, 0, 32'h0, 32'h0,        1, 0, 0, 0));

    foreach (vecs[i]) begin
      reset = vecs[i].rst; load_start_ip = vecs[i].start; byte_valid_ip = vecs[i].valid;
      byte_data_ip = vecs[i].data; wr_gnt_ip = vecs[i].gnt;
      @(posedge clock); #1;
      chk1 ($sformatf("v%0d.ready", i), byte_ready_op, vecs[i].ready);
      chk1 ($sformatf("v%0d.wr_en", i), wr_en_op,      vecs[i].wr_en);
      chk32($sformatf("v%0d.addr", i),  wr_addr_op,    vecs[i].addr);
      chk32($sformatf("v%0d.wdata", i), wr_data_op,    vecs[i].wdata);
      chk1 ($sformatf("v%0d.core_reset", i), core_reset_op, vecs[i].cr);
      chk1 ($sformatf("v%0d.mem_en", i), mem_en_op,    vecs[i].mem);
      chk1 ($sformatf("v%0d.done", i),  done_op,       vecs[i].done);
      chk1 ($sformatf("v%0d.error", i), error_op,      vecs[i].err);
    end
    load_start_ip = 1'b0; byte_valid_ip = 1'b0;
    chk32("t1.nwrites", 32'(log_addr.size()), 32'd2);
    if (log_addr.size() == 2) begin
      chk32("t1.w0.addr", log_addr[0], 32'h0);
      chk32("t1.w0.data", log_data[0], 32'h00000013);
      chk32("t1.w1.addr", log_addr[1], 32'h4);
      chk32("t1.w1.data", log_data[1], 32'h00100093);
    end

    // Header one above the limit fails; exactly the limit fills the region.
    do_reset();
    wr_gnt_ip = 1'b1;
    pulse_start();
    send_byte(8'h21);
    chk1("t3.hdr21.error", error_op, 1'b1);
    chk1("t3.hdr21.ready", byte_ready_op, 1'b0);
    pulse_start();
    chk1("t3.restart.error", error_op, 1'b0);
    send_byte(8'h20);
    xsum = 8'h00;
    for (int wi = 0; wi < 32; wi++) begin
      for (int j = 0; j < 4; j++) begin
        b = 8'(4 * wi + j);
        xsum = xsum ^ b;
        send_byte(b);
      end
    end
`ifdef BOOT_CHECKSUM_EN
    send_byte(xsum);
`endif
    wait_done_or_error();
    chk1("t3.done", done_op, 1'b1);
    chk1("t3.error", error_op, 1'b0);
    chk1("t3.core_reset", core_reset_op, 1'b0);
    chk32("t3.final_addr", wr_addr_op, 32'h7C);
    chk32("t3.nwrites", 32'(log_addr.size()), 32'd32);
    if (log_addr.size() == 32) begin
      chk32("t3.last_addr", log_addr[31], 32'h7C);
      for (int wi = 0; wi < 32; wi++) begin
        w = {8'(4 * wi + 3), 8'(4 * wi + 2), 8'(4 * wi + 1), 8'(4 * wi)};
        chk32($sformatf("t3.w%0d.data", wi), log_data[wi], w);
      end
    end

    // Grant held low: write request and data hold, stalled byte stays pending.
    do_reset();
    wr_gnt_ip = 1'b0;
    pulse_start();
    send_byte(8'h02);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    chk1("t4.wr_en", wr_en_op, 1'b1);
    byte_valid_ip = 1'b1; byte_data_ip = 8'hEE;
    for (int c = 0; c < 5; c++) begin
      @(posedge clock); #1;
      chk1 ($sformatf("t4.hold%0d.wr_en", c), wr_en_op, 1'b1);
      chk32($sformatf("t4.hold%0d.addr", c),  wr_addr_op, 32'h0);
      chk32($sformatf("t4.hold%0d.data", c),  wr_data_op, 32'hDDCCBBAA);
      chk1 ($sformatf("t4.hold%0d.ready", c), byte_ready_op, 1'b0);
    end
    wr_gnt_ip = 1'b1;
    @(posedge clock); #1;
    chk1 ("t4.gnt.wr_en", wr_en_op, 1'b0);
    chk32("t4.gnt.addr",  wr_addr_op, 32'h4);
    chk1 ("t4.gnt.ready", byte_ready_op, 1'b1);
    chk32("t4.gnt.data",  wr_data_op, 32'hDDCCBBAA);
    @(posedge clock); #1;
    byte_valid_ip = 1'b0;
    chk32("t4.pending_byte", wr_data_op, 32'hDDCCBBEE);
    chk32("t4.nwrites", 32'(log_addr.size()), 32'd1);

    // Stream stalls after two payload bytes until the timeout fires.
    do_reset();
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (TMO - 1) @(posedge clock);
    #1;
    chk1("t5.tmo_early.error", error_op, 1'b0);
    @(posedge clock); #1;
    chk1("t5.tmo.error", error_op, 1'b1);
    chk1("t5.tmo.ready", byte_ready_op, 1'b0);
    chk1("t5.tmo.core_reset", core_reset_op, 1'b1);
    chk1("t5.tmo.mem_en", mem_en_op, 1'b0);

    // Reset in the middle of a word.
    do_reset();
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    chk32("t5.partial.data", wr_data_op, 32'h00030201);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk1 ("t5.rst.ready", byte_ready_op, 1'b0);
    chk1 ("t5.rst.wr_en", wr_en_op, 1'b0);
    chk32("t5.rst.addr",  wr_addr_op, 32'h0);
    chk32("t5.rst.data",  wr_data_op, 32'h0);
    chk1 ("t5.rst.core_reset", core_reset_op, 1'b1);
    chk1 ("t5.rst.mem_en", mem_en_op, 1'b0);
    chk1 ("t5.rst.done", done_op, 1'b0);
    chk1 ("t5.rst.error", error_op, 1'b0);

`ifdef BOOT_CHECKSUM_EN
    // Wrong checksum byte rejects the program.
    do_reset();
    pulse_start();
    for (int k = 0; k < 9; k++) send_byte(s1[k]);
    send_byte(8'h91);
    wait_done_or_error();
    chk1("t6.bad.error", error_op, 1'b1);
    chk1("t6.bad.done", done_op, 1'b0);
    chk1("t6.bad.mem_en", mem_en_op, 1'b0);
    chk1("t6.bad.core_reset", core_reset_op, 1'b1);
`else
    // Same stream sent by task: no checksum phase, done straight after the last grant.
    do_reset();
    pulse_start();
    for (int k = 0; k < 9; k++) send_byte(s1[k]);
    wait_done_or_error();
    chk1("t6.nock.done", done_op, 1'b1);
    chk1("t6.nock.mem_en", mem_en_op, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
